carpma_birimi: RTL and testbench
================================

CARPMA_BIRIMI -- requirements
Module: carpma_birimi

Interface
REQ-001 Parameter CARPICI_GECIKME, 3, fixed latency in cycles from carpici_* inputs to carpim_i.
REQ-002 Parameter SONUC_DERINLIK, 5, result FIFO depth in entries; minimum 2.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 istek_gecerli_i  in  1  request valid.
REQ-006 istek_hazir_o  out  1  request ready.
REQ-007 istek_islem_i  in  2  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
REQ-008 istek_islec0_i / istek_islec1_i  in  32 each  rs1 / rs2.
REQ-009 istek_etiket_i  in  5  destination register tag.
REQ-010 iptal_i  in  1  flush.
REQ-011 carpici_islec0_o / carpici_islec1_o  out  32 each  operands to the multiplier.
REQ-012 carpici_islec0_isaretli_o / carpici_islec1_isaretli_o  out  1 each  signedness flags to the multiplier.
REQ-013 carpici_gecerli_o  out  1  multiplier issue strobe.
REQ-014 carpim_i  in  64  multiplier product.
REQ-015 sonuc_gecerli_o  out  1  result valid.
REQ-016 sonuc_hazir_i  in  1  consumer ready.
REQ-017 sonuc_o  out  32  result.
REQ-018 sonuc_etiket_o  out  5  tag of the result.

Function
REQ-019 A request is accepted in any cycle where istek_gecerli_i && istek_hazir_o.
REQ-020 istek_hazir_o is (ucusta + doluluk < SONUC_DERINLIK) && !iptal_i.
  - ucusta: operations in the tracking pipeline.
  - doluluk: FIFO occupancy.
  - Both are registered, so there is no combinational path from sonuc_hazir_i.
REQ-021 carpici_islec0_o and carpici_islec1_o are combinational pass-throughs of istek_islec0_i and istek_islec1_i.
REQ-022 carpici_gecerli_o equals the accept condition.
REQ-023 Signedness flags from istek_islem_i:
  - MUL: (1,1)
  - MULH: (1,1)
  - MULHSU: (1,0)
  - MULHU: (0,0)
REQ-024 A tracking shift register of CARPICI_GECIKME stages carries {gecerli, ust_yari, etiket}; ust_yari = (islem != MUL); only gecerli is reset.
REQ-025 The unit never uses the multiplier's own valid output; product validity comes only from the tracking register's last stage.
REQ-026 When the last stage is valid, the unit writes the selected product into the FIFO in that cycle:
  - ust_yari=0: carpim_i[31:0]
  - ust_yari=1: carpim_i[63:32]
  - the entry also carries etiket.
REQ-027 Latency: a request accepted in cycle N appears on sonuc_* in cycle N+CARPICI_GECIKME+1 if the FIFO was empty and not blocked.
REQ-028 Throughput: with sonuc_hazir_i held high and SONUC_DERINLIK >= CARPICI_GECIKME+2, the unit accepts one request per cycle indefinitely.
REQ-029 The FIFO is a first-word registered output.
  - sonuc_gecerli_o = (doluluk != 0).
  - A pop occurs on sonuc_gecerli_o && sonuc_hazir_i.
REQ-030 Simultaneous push and pop leaves doluluk unchanged, with order preserved.
  - A push into a full FIFO cannot occur, by the REQ-020 credit rule.
  - An assertion flags any such push.
REQ-031 Read/write pointers wrap modulo SONUC_DERINLIK, including non-power-of-two depths.
REQ-032 iptal_i high takes effect at the next clock edge:
  - all tracking gecerli bits clear;
  - doluluk becomes 0 and both pointers become 0;
  - istek_hazir_o is 0 in the iptal_i cycle;
  - a product arriving in the iptal_i cycle is discarded;
  - sonuc_gecerli_o drops in the cycle after iptal_i.
REQ-033 sonuc_o and sonuc_etiket_o hold stable while sonuc_gecerli_o && !sonuc_hazir_i.

Reset
REQ-034 While rst_ni is low, asynchronously:
  - all tracking gecerli bits = 0;
  - doluluk = 0 and both FIFO pointers = 0;
  - sonuc_gecerli_o = 0 and istek_hazir_o = 0.
REQ-035 istek_hazir_o rises in the first cycle after rst_ni deasserts.
REQ-036 Reset asserted mid-operation discards all in-flight and buffered results; later carpim_i values for those operations are ignored.
REQ-037 FIFO data storage and tracking etiket/ust_yari bits are not reset.

Structure
REQ-038 A shared package holds:
  - the islem encodings (MUL, MULH, MULHSU, MULHU);
  - the etiket width (5);
  - the data width (32).
REQ-039 The result FIFO is one sub-module, sonuc_fifo, parameterised by depth and entry width.
REQ-040 The multiplier is instantiated by the parent, not inside carpma_birimi.

Verification
The bench connects a 3-cycle behavioural multiplier model.
REQ-041 MULH, rs1=0x80000000, rs2=0x80000000, tag 7, accepted cycle 0 -> sonuc_o=0x40000000, tag 7, valid in cycle 4.
REQ-042 Back-to-back MUL, MULHU, MULHSU on (0xFFFFFFFF, 0xFFFFFFFF), with sonuc_hazir_i=1 -> results 0x00000001, 0xFFFFFFFE, 0xFFFFFFFF in consecutive cycles 4, 5, 6; istek_hazir_o never drops.
REQ-043 sonuc_hazir_i=0 with continuous requests -> exactly 5 accepted, then istek_hazir_o=0; raise sonuc_hazir_i -> all 5 drain in order with correct tags, then acceptance resumes.
REQ-044 Issue 3 requests, assert iptal_i in cycle 2 -> no sonuc_gecerli_o for any of them; a new request in cycle 4 returns its correct result in cycle 8.
REQ-045 Assert rst_ni low in cycle 2 with 2 operations in flight -> sonuc_gecerli_o=0 immediately and through cycle 10; istek_hazir_o=1 in the first cycle after release.
REQ-046 Random stall pattern on sonuc_hazir_i, 10k operations -> scoreboard match, sonuc_o stable while stalled, no overflow assertion.

Source files
------------

// File: rtl/carpma_birimi_pkg.sv
// ---------------------------------------------------------------------------
// carpma_birimi_pkg
// Definitions shared by the multiply unit and its result FIFO:
//   - islem_t: operation encodings (MUL, MULH, MULHSU, MULHU)
//   - VERI_W: data width of operands and results
//   - ETIKET_W: destination register tag width
//   - isaret_bayraklari(): operand signedness flags for an operation
// ---------------------------------------------------------------------------
package carpma_birimi_pkg;

   localparam int VERI_W   = 32;
   localparam int ETIKET_W = 5;

   typedef enum logic [1:0] {
      ISLEM_MUL    = 2'd0,
      ISLEM_MULH   = 2'd1,
      ISLEM_MULHSU = 2'd2,
      ISLEM_MULHU  = 2'd3
   } islem_t;

   // Returns {islec0_isaretli, islec1_isaretli}. MUL uses the signed form
   // because the low half of the product is the same either way.
   function automatic logic [1:0] isaret_bayraklari(input islem_t islem);
      case (islem)
         ISLEM_MUL, ISLEM_MULH: return 2'b11;
         ISLEM_MULHSU:          return 2'b10;
         default:               return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/carpma_birimi_sonuc_fifo.sv
// ---------------------------------------------------------------------------
// sonuc_fifo
// Result FIFO with the head entry read straight out of storage, so the output
// word is registered and stays put until it is popped.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   temizle_i       flush: empties the FIFO and zeroes both pointers
//   yaz_i           push yaz_veri_i (never issued while full)
//   oku_hazir_i     consumer ready; a pop happens when oku_gecerli_o is also high
//   oku_gecerli_o   FIFO holds at least one entry
//   oku_veri_o      head entry
//   doluluk_o       current occupancy
// ---------------------------------------------------------------------------
module sonuc_fifo #(
   parameter int DERINLIK = 5,
   parameter int GENISLIK = 37
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         temizle_i,
   input  logic                         yaz_i,
   input  logic [GENISLIK-1:0]          yaz_veri_i,
   input  logic                         oku_hazir_i,
   output logic                         oku_gecerli_o,
   output logic [GENISLIK-1:0]          oku_veri_o,
   output logic [$clog2(DERINLIK+1)-1:0] doluluk_o
);

   localparam int PTR_W = $clog2(DERINLIK);
   localparam int SAY_W = $clog2(DERINLIK+1);

   logic [GENISLIK-1:0] bellek [DERINLIK];
   logic [PTR_W-1:0]    yaz_ptr_q;
   logic [PTR_W-1:0]    oku_ptr_q;
   logic [SAY_W-1:0]    doluluk_q;
   logic                oku;

   // Pointers wrap explicitly at the last slot so depths that are not a
   // power of two still cycle through exactly DERINLIK entries.
   function automatic logic [PTR_W-1:0] ilerle(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DERINLIK-1)) begin
         return '0;
      end
      return ptr + PTR_W'(1);
   endfunction

   assign oku_gecerli_o = (doluluk_q != '0);
   assign oku           = oku_gecerli_o && oku_hazir_i;
   assign oku_veri_o    = bellek[oku_ptr_q];
   assign doluluk_o     = doluluk_q;

   // Pointer and occupancy bookkeeping. A flush overrides any push or pop in
   // the same cycle; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         yaz_ptr_q <= '0;
         oku_ptr_q <= '0;
         doluluk_q <= '0;
      end else if (temizle_i) begin
         yaz_ptr_q <= '0;
         oku_ptr_q <= '0;
         doluluk_q <= '0;
      end else begin
         if (yaz_i) begin
            yaz_ptr_q <= ilerle(yaz_ptr_q);
         end
         if (oku) begin
            oku_ptr_q <= ilerle(oku_ptr_q);
         end
         if (yaz_i && !oku) begin
            doluluk_q <= doluluk_q + SAY_W'(1);
         end else if (!yaz_i && oku) begin
            doluluk_q <= doluluk_q - SAY_W'(1);
         end
      end
   end

   // Storage is deliberately left out of reset; only the pointers decide
   // which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (yaz_i) begin
         bellek[yaz_ptr_q] <= yaz_veri_i;
      end
   end

   // The upstream credit scheme guarantees a free slot for every push, so a
   // push while full means that scheme has been broken.
   always_ff @(posedge clk_i) begin
      if (rst_ni && !temizle_i && yaz_i) begin
         tasma_yok: assert (doluluk_q != SAY_W'(DERINLIK));
      end
   end

endmodule

// File: rtl/carpma_birimi.sv
// ---------------------------------------------------------------------------
// carpma_birimi
// Front end for an external fixed-latency multiplier. Requests are forwarded
// to the multiplier, tracked through a shift register matching its latency,
// and the selected half of each product is buffered in a result FIFO.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   istek_gecerli_i/istek_hazir_o request handshake
//   istek_islem_i                 operation (islem_t)
//   istek_islec0_i/istek_islec1_i rs1 / rs2 operands
//   istek_etiket_i                destination tag
//   iptal_i                       flush of all in-flight and buffered work
//   carpici_*_o                   operands, signedness and issue strobe
//   carpim_i                      64-bit product, CARPICI_GECIKME cycles later
//   sonuc_gecerli_o/sonuc_hazir_i result handshake
//   sonuc_o, sonuc_etiket_o       result word and its tag
// ---------------------------------------------------------------------------
module carpma_birimi
   import carpma_birimi_pkg::*;
#(
   parameter int CARPICI_GECIKME = 3,
   parameter int SONUC_DERINLIK  = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  istek_gecerli_i,
   output logic                  istek_hazir_o,
   input  logic [1:0]            istek_islem_i,
   input  logic [VERI_W-1:0]     istek_islec0_i,
   input  logic [VERI_W-1:0]     istek_islec1_i,
   input  logic [ETIKET_W-1:0]   istek_etiket_i,
   input  logic                  iptal_i,
   output logic [VERI_W-1:0]     carpici_islec0_o,
   output logic [VERI_W-1:0]     carpici_islec1_o,
   output logic                  carpici_islec0_isaretli_o,
   output logic                  carpici_islec1_isaretli_o,
   output logic                  carpici_gecerli_o,
   input  logic [2*VERI_W-1:0]   carpim_i,
   output logic                  sonuc_gecerli_o,
   input  logic                  sonuc_hazir_i,
   output logic [VERI_W-1:0]     sonuc_o,
   output logic [ETIKET_W-1:0]   sonuc_etiket_o
);

   localparam int L        = CARPICI_GECIKME;
   localparam int UCUSTA_W = $clog2(CARPICI_GECIKME+1);
   localparam int TOPLAM_W = $clog2(CARPICI_GECIKME+SONUC_DERINLIK+1);
   localparam int GIRDI_W  = VERI_W + ETIKET_W;

   logic [L-1:0]                       izci_gecerli_q;
   logic [L-1:0]                       izci_ust_q;
   logic [ETIKET_W-1:0]                izci_etiket_q [L];
   logic [UCUSTA_W-1:0]                ucusta;
   logic [$clog2(SONUC_DERINLIK+1)-1:0] doluluk;
   logic [TOPLAM_W-1:0]                toplam;
   logic                               kabul;
   logic                               ust_yari;
   logic [1:0]                         bayraklar;
   logic                               fifo_yaz;
   logic [VERI_W-1:0]                  secili_carpim;
   logic [GIRDI_W-1:0]                 fifo_cikis;

   // Credit check: every operation in the tracking pipe already owns a FIFO
   // slot, so in-flight plus buffered must stay below the FIFO depth. Both
   // terms are registered, so sonuc_hazir_i never reaches istek_hazir_o.
   always_comb begin
      ucusta = '0;
      for (int i = 0; i < L; i++) begin
         ucusta = ucusta + UCUSTA_W'(izci_gecerli_q[i]);
      end
   end

   assign toplam        = TOPLAM_W'(ucusta) + TOPLAM_W'(doluluk);
   assign istek_hazir_o = rst_ni && !iptal_i && (toplam < TOPLAM_W'(SONUC_DERINLIK));
   assign kabul         = istek_gecerli_i && istek_hazir_o;

   // Requests go straight to the multiplier; signedness comes from the
   // operation and the issue strobe is the handshake itself.
   always_comb begin
      bayraklar = isaret_bayraklari(islem_t'(istek_islem_i));
      ust_yari  = (islem_t'(istek_islem_i) != ISLEM_MUL);
   end

   assign carpici_islec0_o          = istek_islec0_i;
   assign carpici_islec1_o          = istek_islec1_i;
   assign carpici_islec0_isaretli_o = bayraklar[1];
   assign carpici_islec1_isaretli_o = bayraklar[0];
   assign carpici_gecerli_o         = kabul;

   // Valid bits of the tracking pipe. They alone decide when a product is
   // real; a flush or reset clears them so late products are ignored.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         izci_gecerli_q <= '0;
      end else if (iptal_i) begin
         izci_gecerli_q <= '0;
      end else begin
         izci_gecerli_q <= (izci_gecerli_q << 1) | L'(kabul);
      end
   end

   // Half-select and tag travel alongside the valid bits but need no reset,
   // since they are only looked at when the matching valid bit is set.
   always_ff @(posedge clk_i) begin
      izci_ust_q       <= (izci_ust_q << 1) | L'(ust_yari);
      izci_etiket_q[0] <= istek_etiket_i;
      for (int i = 1; i < L; i++) begin
         izci_etiket_q[i] <= izci_etiket_q[i-1];
      end
   end

   // The product lines up with the last tracking stage; a product landing in
   // a flush cycle is dropped.
   assign fifo_yaz      = izci_gecerli_q[L-1] && !iptal_i;
   assign secili_carpim = izci_ust_q[L-1] ? carpim_i[2*VERI_W-1:VERI_W]
                                          : carpim_i[VERI_W-1:0];

   sonuc_fifo #(
      .DERINLIK (SONUC_DERINLIK),
      .GENISLIK (GIRDI_W)
   ) u_sonuc_fifo (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .temizle_i     (iptal_i),
      .yaz_i         (fifo_yaz),
      .yaz_veri_i    ({izci_etiket_q[L-1], secili_carpim}),
      .oku_hazir_i   (sonuc_hazir_i),
      .oku_gecerli_o (sonuc_gecerli_o),
      .oku_veri_o    (fifo_cikis),
      .doluluk_o     (doluluk)
   );

   assign sonuc_o        = fifo_cikis[VERI_W-1:0];
   assign sonuc_etiket_o = fifo_cikis[GIRDI_W-1:VERI_W];

endmodule

// File: tb/tb_carpma_birimi.sv
// ---------------------------------------------------------------------------
// tb_carpma_birimi
// Bench for carpma_birimi with a 3-cycle behavioural multiplier. A queue of
// expected results, computed straight from the operation definitions, is
// compared against every result handshake; credit and latency are derived
// from the queue contents.
// ---------------------------------------------------------------------------
module tb_carpma_birimi;
   import carpma_birimi_pkg::*;

   localparam int GECIKME  = 3;
   localparam int DERINLIK = 5;

   logic        clk_i;
   logic        rst_ni;
   logic        istek_gecerli_i;
   logic        istek_hazir_o;
   logic [1:0]  istek_islem_i;
   logic [31:0] istek_islec0_i;
   logic [31:0] istek_islec1_i;
   logic [4:0]  istek_etiket_i;
   logic        iptal_i;
   logic [31:0] carpici_islec0_o;
   logic [31:0] carpici_islec1_o;
   logic        carpici_islec0_isaretli_o;
   logic        carpici_islec1_isaretli_o;
   logic        carpici_gecerli_o;
   logic [63:0] carpim_i;
   logic        sonuc_gecerli_o;
   logic        sonuc_hazir_i;
   logic [31:0] sonuc_o;
   logic [4:0]  sonuc_etiket_o;

   carpma_birimi #(
      .CARPICI_GECIKME (GECIKME),
      .SONUC_DERINLIK  (DERINLIK)
   ) dut (
      .clk_i                     (clk_i),
      .rst_ni                    (rst_ni),
      .istek_gecerli_i           (istek_gecerli_i),
      .istek_hazir_o             (istek_hazir_o),
      .istek_islem_i             (istek_islem_i),
      .istek_islec0_i            (istek_islec0_i),
      .istek_islec1_i            (istek_islec1_i),
      .istek_etiket_i            (istek_etiket_i),
      .iptal_i                   (iptal_i),
      .carpici_islec0_o          (carpici_islec0_o),
      .carpici_islec1_o          (carpici_islec1_o),
      .carpici_islec0_isaretli_o (carpici_islec0_isaretli_o),
      .carpici_islec1_isaretli_o (carpici_islec1_isaretli_o),
      .carpici_gecerli_o         (carpici_gecerli_o),
      .carpim_i                  (carpim_i),
      .sonuc_gecerli_o           (sonuc_gecerli_o),
      .sonuc_hazir_i             (sonuc_hazir_i),
      .sonuc_o                   (sonuc_o),
      .sonuc_etiket_o            (sonuc_etiket_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Behavioural multiplier: 33x33 signed product of the flag-extended
   // operands, delayed by three registers. It ignores the issue strobe.
   logic [63:0] p1, p2, p3;

   function automatic logic [63:0] carpFn(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb);
      logic signed [65:0] ea, eb, pr;
      ea = {{34{sa & a[31]}}, a};
      eb = {{34{sb & b[31]}}, b};
      pr = ea * eb;
      return pr[63:0];
   endfunction

   always @(posedge clk_i) begin
      p1 <= carpFn(carpici_islec0_o, carpici_islec1_o,
                   carpici_islec0_isaretli_o, carpici_islec1_isaretli_o);
      p2 <= p1;
      p3 <= p2;
   end
   assign carpim_i = p3;

   // Reference results straight from the instruction definitions.
   function automatic logic [31:0] refSonuc(input logic [1:0] islem,
                                            input logic [31:0] a, input logic [31:0] b);
      logic [63:0] uu, ss, su;
      uu = {32'b0, a} * {32'b0, b};
      ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      su = {{32{a[31]}}, a} * {32'b0, b};
      case (islem)
         2'd0:    return uu[31:0];
         2'd1:    return ss[63:32];
         2'd2:    return su[63:32];
         default: return uu[63:32];
      endcase
   endfunction

   function automatic logic [1:0] refBayrak(input logic [1:0] islem);
      case (islem)
         2'd0, 2'd1: return 2'b11;
         2'd2:       return 2'b10;
         default:    return 2'b00;
      endcase
   endfunction

   function automatic logic [31:0] rastgeleIslec();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   typedef struct {
      logic [31:0] sonuc;
      logic [4:0]  etiket;
      int          hazirDongu;
   } beklenen_t;

   beklenen_t   kuyruk[$];
   int          dongu;
   int          assertCount;
   int          failCount;
   int          kabulSayisi;
   logic        obsValid, obsHazir, obsKabul;
   logic [31:0] obsSonuc;
   logic [4:0]  obsEtiket;
   logic        prevStall;
   logic [31:0] prevSonuc;
   logic [4:0]  prevEtiket;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)",
                  tag, observed, expected, dongu);
      end
   endtask

   // Drives one cycle of inputs, samples 1 time unit later, checks the
   // handshake outputs against the queue model, then advances to the next
   // falling edge.
   task automatic applyStimulus(input logic gecerli, input logic [1:0] islem,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] etiket, input logic iptal,
                                input logic hazir);
      logic      expHazir, expValid;
      logic [1:0] expBayrak;
      beklenen_t bk;
      istek_gecerli_i = gecerli;
      istek_islem_i   = islem;
      istek_islec0_i  = a;
      istek_islec1_i  = b;
      istek_etiket_i  = etiket;
      iptal_i         = iptal;
      sonuc_hazir_i   = hazir;
      #1;
      obsValid  = sonuc_gecerli_o;
      obsHazir  = istek_hazir_o;
      obsSonuc  = sonuc_o;
      obsEtiket = sonuc_etiket_o;
      obsKabul  = gecerli && obsHazir;

      expHazir = rst_ni && !iptal && (kuyruk.size() < DERINLIK);
      expValid = rst_ni && (kuyruk.size() > 0) && (kuyruk[0].hazirDongu <= dongu);
      expBayrak = refBayrak(islem);
      checkOutput("istek_hazir", 64'(obsHazir), 64'(expHazir));
      checkOutput("sonuc_gecerli", 64'(obsValid), 64'(expValid));
      checkOutput("carpici_gecerli", 64'(carpici_gecerli_o), 64'(gecerli && expHazir));
      checkOutput("carpici_islec0", 64'(carpici_islec0_o), 64'(a));
      checkOutput("carpici_islec1", 64'(carpici_islec1_o), 64'(b));
      checkOutput("carpici_isaret",
                  64'({carpici_islec0_isaretli_o, carpici_islec1_isaretli_o}), 64'(expBayrak));

      if (prevStall && obsValid) begin
         checkOutput("sabit_sonuc", 64'(obsSonuc), 64'(prevSonuc));
         checkOutput("sabit_etiket", 64'(obsEtiket), 64'(prevEtiket));
      end

      if (obsValid && hazir) begin
         if (kuyruk.size() == 0) begin
            checkOutput("beklenmeyen_sonuc", 64'(1), 64'(0));
         end else begin
            bk = kuyruk.pop_front();
            checkOutput("sonuc", 64'(obsSonuc), 64'(bk.sonuc));
            checkOutput("etiket", 64'(obsEtiket), 64'(bk.etiket));
         end
      end

      if (obsKabul) begin
         bk.sonuc      = refSonuc(islem, a, b);
         bk.etiket     = etiket;
         bk.hazirDongu = dongu + GECIKME + 1;
         kuyruk.push_back(bk);
         kabulSayisi++;
      end

      prevStall  = obsValid && !hazir && !iptal && rst_ni;
      prevSonuc  = obsSonuc;
      prevEtiket = obsEtiket;
      if (iptal || !rst_ni) begin
         kuyruk.delete();
      end
      @(negedge clk_i);
      dongu++;
   endtask

   task automatic bosDongu(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
      end
   endtask

   initial begin
      int sayac;
      int sinir;
      logic gec, haz;
      assertCount     = 0;
      failCount       = 0;
      kabulSayisi     = 0;
      dongu           = 0;
      prevStall       = 1'b0;
      prevSonuc       = '0;
      prevEtiket      = '0;
      rst_ni          = 1'b0;
      istek_gecerli_i = 1'b0;
      istek_islem_i   = 2'd0;
      istek_islec0_i  = '0;
      istek_islec1_i  = '0;
      istek_etiket_i  = '0;
      iptal_i         = 1'b0;
      sonuc_hazir_i   = 1'b1;
      @(negedge clk_i);

      $display("[TB] reset state");
      applyStimulus(1'b1, 2'd0, 32'h1, 32'h1, 5'd1, 1'b0, 1'b1);
      checkOutput("reset_hazir", 64'(obsHazir), 64'(0));
      bosDongu(1);
      rst_ni = 1'b1;

      $display("[TB] MULH single op latency");
      applyStimulus(1'b1, ISLEM_MULH, 32'h8000_0000, 32'h8000_0000, 5'd7, 1'b0, 1'b1);
      checkOutput("ilk_hazir", 64'(obsHazir), 64'(1));
      bosDongu(3);
      checkOutput("mulh_erken", 64'(obsValid), 64'(0));
      bosDongu(1);
      checkOutput("mulh_gecerli", 64'(obsValid), 64'(1));
      checkOutput("mulh_sonuc", 64'(obsSonuc), 64'(32'h4000_0000));
      checkOutput("mulh_etiket", 64'(obsEtiket), 64'(7));
      bosDongu(2);

      $display("[TB] back-to-back MUL/MULHU/MULHSU");
      applyStimulus(1'b1, ISLEM_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0, 1'b1);
      checkOutput("b2b_hazir0", 64'(obsHazir), 64'(1));
      applyStimulus(1'b1, ISLEM_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, 1'b1);
      checkOutput("b2b_hazir1", 64'(obsHazir), 64'(1));
      applyStimulus(1'b1, ISLEM_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, 1'b1);
      checkOutput("b2b_hazir2", 64'(obsHazir), 64'(1));
      bosDongu(2);
      checkOutput("b2b_mul", 64'({obsValid, obsSonuc}), 64'({1'b1, 32'h0000_0001}));
      bosDongu(1);
      checkOutput("b2b_mulhu", 64'({obsValid, obsSonuc}), 64'({1'b1, 32'hFFFF_FFFE}));
      bosDongu(1);
      checkOutput("b2b_mulhsu", 64'({obsValid, obsSonuc}), 64'({1'b1, 32'hFFFF_FFFF}));
      bosDongu(2);

      $display("[TB] backpressure fills credits");
      sayac = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 2'(i), rastgeleIslec(), rastgeleIslec(), 5'(i + 10), 1'b0, 1'b0);
         if (obsKabul) sayac++;
      end
      checkOutput("dolu_kabul", 64'(sayac), 64'(DERINLIK));
      checkOutput("dolu_hazir", 64'(obsHazir), 64'(0));
      bosDongu(8);
      checkOutput("bosaldi", 64'(kuyruk.size()), 64'(0));
      applyStimulus(1'b1, ISLEM_MUL, 32'd6, 32'd7, 5'd4, 1'b0, 1'b1);
      checkOutput("devam_kabul", 64'(obsKabul), 64'(1));
      bosDongu(6);

      $display("[TB] flush");
      applyStimulus(1'b1, ISLEM_MUL, 32'd3, 32'd5, 5'd20, 1'b0, 1'b1);
      applyStimulus(1'b1, ISLEM_MULHU, 32'hFFFF_0000, 32'h0001_0000, 5'd21, 1'b0, 1'b1);
      applyStimulus(1'b1, ISLEM_MULH, 32'd9, 32'd9, 5'd22, 1'b1, 1'b1);
      checkOutput("iptal_hazir", 64'(obsHazir), 64'(0));
      bosDongu(1);
      checkOutput("iptal_sonrasi", 64'(obsValid), 64'(0));
      applyStimulus(1'b1, ISLEM_MULH, 32'h0001_0000, 32'h0003_0000, 5'd9, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         bosDongu(1);
         checkOutput("iptal_sessiz", 64'(obsValid), 64'(0));
      end
      bosDongu(1);
      checkOutput("iptal_yeni", 64'({obsValid, obsEtiket, obsSonuc}),
                  64'({1'b1, 5'd9, 32'h0000_0003}));
      bosDongu(2);

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, ISLEM_MUL, 32'd11, 32'd13, 5'd5, 1'b0, 1'b1);
      applyStimulus(1'b1, ISLEM_MUL, 32'd17, 32'd19, 5'd6, 1'b0, 1'b1);
      rst_ni = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bosDongu(1);
         checkOutput("reset_gecerli", 64'(obsValid), 64'(0));
      end
      rst_ni = 1'b1;
      bosDongu(1);
      checkOutput("reset_sonrasi_hazir", 64'(obsHazir), 64'(1));
      for (int i = 0; i < 5; i++) begin
         bosDongu(1);
         checkOutput("reset_sessiz", 64'(obsValid), 64'(0));
      end

      $display("[TB] random stall run");
      sayac = kabulSayisi;
      sinir = 0;
      while ((kabulSayisi - sayac) < 10000 && sinir < 40000) begin
         gec = ($urandom_range(0, 3) != 0);
         haz = ($urandom_range(0, 99) < 60);
         applyStimulus(gec, 2'($urandom_range(0, 3)), rastgeleIslec(), rastgeleIslec(),
                       5'($urandom_range(0, 31)), 1'b0, haz);
         sinir++;
      end
      checkOutput("rastgele_tamam", 64'((kabulSayisi - sayac) >= 10000), 64'(1));
      bosDongu(20);
      checkOutput("rastgele_bos", 64'(kuyruk.size()), 64'(0));

      $display("[TB] End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
